// File: rtl/issue_queue_alu0_pkg.sv
// ---------------------------------------------------------------------------
// issue_queue_alu0_pkg
// Shared widths, ALU0 opcode encodings, the queue entry layout and the
// source-readiness helper used by the ALU0 issue queue.
// No ports (package).
// ---------------------------------------------------------------------------
package issue_queue_alu0_pkg;

    localparam int IQ_DEPTH = 8;
    localparam int OP_W     = 5;
    localparam int PR_W     = 6;
    localparam int ROB_W    = 6;
    localparam int CNT_W    = 4;

    typedef enum logic [OP_W-1:0] {
        ALU0_ADD   = 5'd0,
        ALU0_SUB   = 5'd1,
        ALU0_AND   = 5'd2,
        ALU0_OR    = 5'd3,
        ALU0_XOR   = 5'd4,
        ALU0_NOR   = 5'd5,
        ALU0_SLL   = 5'd6,
        ALU0_SRL   = 5'd7,
        ALU0_SRA   = 5'd8,
        ALU0_SLT   = 5'd9,
        ALU0_SLTU  = 5'd10,
        ALU0_ADDI  = 5'd11,
        ALU0_ANDI  = 5'd12,
        ALU0_ORI   = 5'd13,
        ALU0_XORI  = 5'd14,
        ALU0_SLTI  = 5'd15,
        ALU0_SLTIU = 5'd16,
        ALU0_SLLI  = 5'd17,
        ALU0_SRLI  = 5'd18,
        ALU0_SRAI  = 5'd19,
        ALU0_LUI   = 5'd20,
        ALU0_AUIPC = 5'd21,
        ALU0_MOV   = 5'd22,
        ALU0_NOP   = 5'd23
    } alu0_op_e;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [PR_W-1:0]  dest;
        logic [ROB_W-1:0] rob_id;
        logic [PR_W-1:0]  src1;
        logic             src1_rdy;
        logic [PR_W-1:0]  src2;
        logic             src2_rdy;
    } iq_entry_t;

    // A source becomes ready if it already was, if it names the hard-wired
    // zero register, or if either wakeup bus broadcasts its tag this cycle.
    function automatic logic src_ready(
        input logic [PR_W-1:0] tag,
        input logic            rdy,
        input logic            wa_vld,
        input logic [PR_W-1:0] wa_pr,
        input logic            wb_vld,
        input logic [PR_W-1:0] wb_pr
    );
        return rdy | (tag == '0) | (wa_vld && (tag == wa_pr)) | (wb_vld && (tag == wb_pr));
    endfunction

endpackage

// File: rtl/issue_queue_alu0_select.sv
// ---------------------------------------------------------------------------
// iq_select_alu0
// Lowest-index-first priority encoder for the ALU0 issue queue.
// Ports:
//   req  - per-entry ready requests (bit 0 = oldest entry)
//   gnt  - one-hot grant of the lowest set request bit (all zero if none)
//   idx  - binary index of the granted entry (0 when nothing is granted)
// ---------------------------------------------------------------------------
module iq_select_alu0 #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                gnt[i] = 1'b1;
                idx    = IW'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue_alu0.sv
// ---------------------------------------------------------------------------
// issue_queue_alu0
// Collapsing issue queue feeding the ALU0 execute stage. Entry 0 is the
// oldest; valid entries are contiguous from 0. Each cycle the oldest entry
// with both sources ready is selected, its destination tag is broadcast
// combinationally on ALU0_wake_*, and its payload is registered onto the
// ALU0_* issue outputs at the next edge.
//
// Ports:
//   clk, rst               - rising-edge clock, async active-high reset
//   disp_*                 - dispatch of one instruction per cycle
//   BRU_wake_vld/PR        - branch unit destination broadcast
//   flush                  - squash all queued and issuing work
//   iq_full, iq_cnt        - occupancy status (from registered count)
//   ALU0_vld, ALU0_*       - issued instruction, one cycle after select
//   ALU0_wake_vld/PR       - tag of the entry selected this cycle
//
// Handshake: dispatch is accepted on a clock edge when disp_vld=1 and
// iq_full=0; a dispatch presented while iq_full=1 is silently dropped, so
// the dispatcher must treat iq_full as its ready (inverted). The issue side
// has no back-pressure: ALU0 accepts every cycle that ALU0_vld=1.
// ---------------------------------------------------------------------------
module issue_queue_alu0
    import issue_queue_alu0_pkg::*;
#(
    parameter int IQ_DEPTH = issue_queue_alu0_pkg::IQ_DEPTH
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             disp_vld,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [PR_W-1:0]  disp_dest,
    input  logic [ROB_W-1:0] disp_ROB_ID,
    input  logic [PR_W-1:0]  disp_PR_source1,
    input  logic             disp_src1_rdy,
    input  logic [PR_W-1:0]  disp_PR_source2,
    input  logic             disp_src2_rdy,

    input  logic             BRU_wake_vld,
    input  logic [PR_W-1:0]  BRU_wake_PR,

    input  logic             flush,

    output logic             iq_full,
    output logic [CNT_W-1:0] iq_cnt,

    output logic             ALU0_vld,
    output logic [OP_W-1:0]  ALU0_op,
    output logic [PR_W-1:0]  ALU0_dest,
    output logic [ROB_W-1:0] ALU0_ROB_ID,
    output logic [PR_W-1:0]  ALU0_PR_source1,
    output logic [PR_W-1:0]  ALU0_PR_source2,

    output logic             ALU0_wake_vld,
    output logic [PR_W-1:0]  ALU0_wake_PR
);

    localparam int IW   = $clog2(IQ_DEPTH);
    localparam int LAST = IQ_DEPTH - 1;

    iq_entry_t           ent_q [IQ_DEPTH];
    iq_entry_t           ent_n [IQ_DEPTH];
    iq_entry_t           woken [IQ_DEPTH];
    logic [IQ_DEPTH-1:0] vld_q;
    logic [IQ_DEPTH-1:0] vld_n;
    logic [IQ_DEPTH-1:0] rdy_vec;
    logic [IQ_DEPTH-1:0] sel_req;
    logic [IQ_DEPTH-1:0] sel_gnt;
    logic [IW-1:0]       sel_idx;
    logic                sel_any;
    iq_entry_t           sel_ent;
    iq_entry_t           disp_ent;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_n;
    logic [CNT_W-1:0]    wr_idx;
    logic                disp_ok;

    // ---------------- select ----------------
    always_comb begin
        rdy_vec = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            rdy_vec[i] = vld_q[i] & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
        end
        // Flush suppresses selection so nothing issues or wakes up.
        sel_req = flush ? '0 : rdy_vec;
    end

    iq_select_alu0 #(
        .N  (IQ_DEPTH),
        .IW (IW)
    ) u_select (
        .req (sel_req),
        .gnt (sel_gnt),
        .idx (sel_idx)
    );

    assign sel_any       = |sel_gnt;
    assign sel_ent       = ent_q[sel_idx];
    assign ALU0_wake_vld = sel_any;
    assign ALU0_wake_PR  = sel_ent.dest;

    // ---------------- wakeup ----------------
    // Both stored entries and the instruction being dispatched see this
    // cycle's broadcasts, so a dependent is never left waiting forever.
    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            woken[i]          = ent_q[i];
            woken[i].src1_rdy = src_ready(ent_q[i].src1, ent_q[i].src1_rdy,
                                          sel_any, sel_ent.dest, BRU_wake_vld, BRU_wake_PR);
            woken[i].src2_rdy = src_ready(ent_q[i].src2, ent_q[i].src2_rdy,
                                          sel_any, sel_ent.dest, BRU_wake_vld, BRU_wake_PR);
        end
        disp_ent.op       = disp_op;
        disp_ent.dest     = disp_dest;
        disp_ent.rob_id   = disp_ROB_ID;
        disp_ent.src1     = disp_PR_source1;
        disp_ent.src2     = disp_PR_source2;
        disp_ent.src1_rdy = src_ready(disp_PR_source1, disp_src1_rdy,
                                      sel_any, sel_ent.dest, BRU_wake_vld, BRU_wake_PR);
        disp_ent.src2_rdy = src_ready(disp_PR_source2, disp_src2_rdy,
                                      sel_any, sel_ent.dest, BRU_wake_vld, BRU_wake_PR);
    end

    // ---------------- occupancy ----------------
    assign iq_full = (cnt_q == CNT_W'(IQ_DEPTH));
    assign iq_cnt  = cnt_q;
    assign disp_ok = disp_vld & ~iq_full;
    // The new entry lands just above the surviving entries after collapse.
    assign wr_idx  = cnt_q - CNT_W'(sel_any);
    assign cnt_n   = wr_idx + CNT_W'(disp_ok);

    // ---------------- collapse + insert ----------------
    always_comb begin
        ent_n[LAST] = woken[LAST];
        vld_n       = vld_q;
        // The top slot always empties on issue: the selected index is at
        // or below it, so everything above moves down by one.
        if (sel_any) begin
            vld_n[LAST] = 1'b0;
        end
        for (int i = 0; i < LAST; i++) begin
            if (sel_any && (IW'(i) >= sel_idx)) begin
                ent_n[i] = woken[i+1];
                vld_n[i] = vld_q[i+1];
            end else begin
                ent_n[i] = woken[i];
                vld_n[i] = vld_q[i];
            end
        end
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (disp_ok && (CNT_W'(i) == wr_idx)) begin
                ent_n[i] = disp_ent;
                vld_n[i] = 1'b1;
            end
        end
    end

    // ---------------- state ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            cnt_q    <= '0;
            ALU0_vld <= 1'b0;
        end else if (flush) begin
            vld_q    <= '0;
            cnt_q    <= '0;
            ALU0_vld <= 1'b0;
        end else begin
            vld_q    <= vld_n;
            cnt_q    <= cnt_n;
            ALU0_vld <= sel_any;
        end
    end

    // Payload is qualified by the valid bits above, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_q <= ent_n;
        if (sel_any) begin
            ALU0_op         <= sel_ent.op;
            ALU0_dest       <= sel_ent.dest;
            ALU0_ROB_ID     <= sel_ent.rob_id;
            ALU0_PR_source1 <= sel_ent.src1;
            ALU0_PR_source2 <= sel_ent.src2;
        end
    end

endmodule

// File: tb/tb_issue_queue_alu0.sv
// ---------------------------------------------------------------------------
// tb_issue_queue_alu0
// Self-checking bench for issue_queue_alu0: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_issue_queue_alu0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       disp_vld = 1'b0;
    logic [4:0] disp_op = '0;
    logic [5:0] disp_dest = '0, disp_ROB_ID = '0, disp_PR_source1 = '0, disp_PR_source2 = '0;
    logic       disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
    logic       BRU_wake_vld = 1'b0;
    logic [5:0] BRU_wake_PR = '0;
    logic       flush = 1'b0;
    logic       iq_full;
    logic [3:0] iq_cnt;
    logic       ALU0_vld;
    logic [4:0] ALU0_op;
    logic [5:0] ALU0_dest, ALU0_ROB_ID, ALU0_PR_source1, ALU0_PR_source2;
    logic       ALU0_wake_vld;
    logic [5:0] ALU0_wake_PR;

    issue_queue_alu0 #(.IQ_DEPTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .disp_vld        (disp_vld),
        .disp_op         (disp_op),
        .disp_dest       (disp_dest),
        .disp_ROB_ID     (disp_ROB_ID),
        .disp_PR_source1 (disp_PR_source1),
        .disp_src1_rdy   (disp_src1_rdy),
        .disp_PR_source2 (disp_PR_source2),
        .disp_src2_rdy   (disp_src2_rdy),
        .BRU_wake_vld    (BRU_wake_vld),
        .BRU_wake_PR     (BRU_wake_PR),
        .flush           (flush),
        .iq_full         (iq_full),
        .iq_cnt          (iq_cnt),
        .ALU0_vld        (ALU0_vld),
        .ALU0_op         (ALU0_op),
        .ALU0_dest       (ALU0_dest),
        .ALU0_ROB_ID     (ALU0_ROB_ID),
        .ALU0_PR_source1 (ALU0_PR_source1),
        .ALU0_PR_source2 (ALU0_PR_source2),
        .ALU0_wake_vld   (ALU0_wake_vld),
        .ALU0_wake_PR    (ALU0_wake_PR)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0] op;
        logic [5:0] dest;
        logic [5:0] rob;
        logic [5:0] s1;
        logic [5:0] s2;
        bit         r1;
        bit         r2;
    } m_ent_t;

    m_ent_t      mq[$];      // queued instructions, oldest first
    logic [28:0] exp_q[$];   // issue payload expected on ALU0_* this cycle

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input logic dv, input logic [4:0] op, input logic [5:0] dest,
                        input logic [5:0] rob, input logic [5:0] s1, input logic r1,
                        input logic [5:0] s2, input logic r2,
                        input logic bv, input logic [5:0] bpr, input logic fl);
        int         sel;
        logic [5:0] sdest;
        bit         was_full;
        m_ent_t     e;
        @(negedge clk);
        disp_vld = dv; disp_op = op; disp_dest = dest; disp_ROB_ID = rob;
        disp_PR_source1 = s1; disp_src1_rdy = r1; disp_PR_source2 = s2; disp_src2_rdy = r2;
        BRU_wake_vld = bv; BRU_wake_PR = bpr; flush = fl;
        #1;
        sel = -1;
        sdest = '0;
        if (!fl) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
            end
        end
        if (sel >= 0) sdest = mq[sel].dest;
        chk("wake_vld", ALU0_wake_vld, sel >= 0);
        if (sel >= 0) chk("wake_pr", ALU0_wake_PR, sdest);
        chk("iq_cnt", iq_cnt, mq.size());
        chk("iq_full", iq_full, mq.size() == 8);
        chk("alu_vld", ALU0_vld, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("alu_payload", {ALU0_op, ALU0_dest, ALU0_ROB_ID, ALU0_PR_source1, ALU0_PR_source2},
                exp_q.pop_front());
        end
        // Model the effect of the coming edge.
        if (fl) begin
            mq.delete();
            exp_q.delete();
        end else begin
            was_full = (mq.size() == 8);
            if (sel >= 0)
                exp_q.push_back({mq[sel].op, mq[sel].dest, mq[sel].rob, mq[sel].s1, mq[sel].s2});
            for (int i = 0; i < mq.size(); i++) begin
                if ((sel >= 0 && mq[i].s1 == sdest) || (bv && mq[i].s1 == bpr)) mq[i].r1 = 1;
                if ((sel >= 0 && mq[i].s2 == sdest) || (bv && mq[i].s2 == bpr)) mq[i].r2 = 1;
            end
            if (sel >= 0) mq.delete(sel);
            if (dv && !was_full) begin
                e.op = op; e.dest = dest; e.rob = rob; e.s1 = s1; e.s2 = s2;
                e.r1 = r1 || (s1 == 0) || (sel >= 0 && s1 == sdest) || (bv && s1 == bpr);
                e.r2 = r2 || (s2 == 0) || (sel >= 0 && s2 == sdest) || (bv && s2 == bpr);
                mq.push_back(e);
            end
        end
    endtask

    task automatic disp(input logic [4:0] op, input logic [5:0] dest, input logic [5:0] rob,
                        input logic [5:0] s1, input logic r1, input logic [5:0] s2, input logic r2);
        step(1'b1, op, dest, rob, s1, r1, s2, r2, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic bru(input logic [5:0] pr);
        step(1'b0, 5'd0, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, pr, 1'b0);
    endtask

    task automatic flush_cyc();
        step(1'b0, 5'd0, 6'd0, 6'd0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        @(negedge clk);
        disp_vld = 1'b0; BRU_wake_vld = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_cnt", iq_cnt, 4'd0);
        chk("rst_full", iq_full, 1'b0);
        chk("rst_alu_vld", ALU0_vld, 1'b0);
        chk("rst_wake_vld", ALU0_wake_vld, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        chk("reset_cnt", iq_cnt, 4'd0);
        chk("reset_full", iq_full, 1'b0);
        chk("reset_alu_vld", ALU0_vld, 1'b0);
        rst = 1'b0;

        // Single ready instruction: wake at +1, issue at +2.
        disp(5'd7, 6'd10, 6'd1, 6'd0, 1'b1, 6'd0, 1'b1);
        idle(3);

        // Producer then dependent: back-to-back issue.
        disp(5'd0, 6'd10, 6'd2, 6'd3, 1'b1, 6'd4, 1'b1);
        disp(5'd1, 6'd11, 6'd3, 6'd10, 1'b0, 6'd0, 1'b1);
        idle(4);

        // Fill with non-ready entries, overflow, then wake entry 3.
        for (int i = 0; i < 8; i++) disp(5'(i), 6'(40 + i), 6'(8 + i), 6'(20 + i), 1'b0, 6'd0, 1'b1);
        disp(5'd2, 6'd50, 6'd30, 6'd0, 1'b1, 6'd0, 1'b1);   // dropped, queue full
        bru(6'd23);
        idle(3);
        flush_cyc();
        idle(1);

        // Entries 0 and 2 become ready together: age order preserved.
        disp(5'd3, 6'd12, 6'd20, 6'd40, 1'b0, 6'd0, 1'b1);
        disp(5'd4, 6'd13, 6'd21, 6'd41, 1'b0, 6'd0, 1'b1);
        disp(5'd5, 6'd14, 6'd22, 6'd40, 1'b0, 6'd0, 1'b1);
        bru(6'd40);
        idle(3);
        bru(6'd41);
        idle(2);

        // Flush with 5 queued; later wakeups must not resurrect them.
        for (int i = 0; i < 5; i++) disp(5'd6, 6'(15 + i), 6'(32 + i), 6'(50 + i), 1'b0, 6'd0, 1'b1);
        flush_cyc();
        for (int i = 0; i < 5; i++) bru(6'(50 + i));
        idle(2);

        // Reset mid-stream with 4 entries, then a normal dispatch.
        for (int i = 0; i < 4; i++) disp(5'd8, 6'(20 + i), 6'(40 + i), 6'(60 + i), 1'b0, 6'd0, 1'b1);
        do_reset();
        disp(5'd9, 6'd33, 6'd44, 6'd0, 1'b1, 6'd0, 1'b1);
        idle(3);

        // Randomized traffic with a small tag space to create dependencies.
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     5'($urandom_range(0, 23)),
                     6'($urandom_range(1, 15)),
                     6'($urandom_range(0, 63)),
                     6'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                     6'($urandom_range(0, 15)), $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0, 6'($urandom_range(0, 15)),
                     $urandom_range(0, 59) == 0);
            end
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_queue_alu0.md
ISSUE_QUEUE_ALU0 -- requirements
Module: issue_queue_alu0

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 8, number of queue entries.
REQ-002 SHALL have ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-003 SHALL have dispatch inputs: disp_vld 1, disp_op 5, disp_dest 6, disp_ROB_ID 6, disp_PR_source1 6, disp_src1_rdy 1, disp_PR_source2 6, disp_src2_rdy 1 (set to 1 for immediate forms).
REQ-004 SHALL have wakeup inputs: BRU_wake_vld 1, BRU_wake_PR 6 (BRU destination broadcast).
REQ-005 SHALL have flush in 1: squash all queued and issuing work.
REQ-006 SHALL have status outputs: iq_full 1, iq_cnt 4 (occupied entries).
REQ-007 SHALL have issue outputs to the ALU0 execute stage: ALU0_vld 1, ALU0_op 5, ALU0_dest 6, ALU0_ROB_ID 6, ALU0_PR_source1 6, ALU0_PR_source2 6.
REQ-008 SHALL have outputs ALU0_wake_vld 1, ALU0_wake_PR 6: combinational tag of the entry selected this cycle.

Function
REQ-009 SHALL hold up to 8 entries in a collapsing queue; entry 0 is oldest, valid entries contiguous from 0.
REQ-010 Each entry SHALL store op, dest, ROB_ID, both source tags, and per-source ready bits.
REQ-011 Entry ready = valid & src1_rdy & src2_rdy; select SHALL pick the lowest-index ready entry, at most one per cycle.
REQ-012 On select, ALU0_wake_vld=1 and ALU0_wake_PR=selected dest in the same cycle; issue outputs SHALL register the selected entry at the next edge (latency 1 from select).
REQ-013 ALU0_vld SHALL be 1 the cycle after a selection, else 0; other issue outputs hold their last value when ALU0_vld=0.
REQ-014 Wakeup: any entry source tag equal to ALU0_wake_PR (when ALU0_wake_vld) or BRU_wake_PR (when BRU_wake_vld) SHALL set its ready bit at the next edge, so a dependent can be selected the cycle after its producer.
REQ-015 Same-cycle wakeup SHALL also apply to the dispatching instruction's sources before storage.
REQ-016 On issue, entries above the selected index SHALL shift down by one in the same edge; the dispatched entry SHALL be written at index (cnt - issued).
REQ-017 iq_full SHALL equal (iq_cnt == 8), computed from registered count; dispatch with iq_full=1 SHALL be dropped, count unchanged except by issue.
REQ-018 Simultaneous dispatch and issue with cnt<8 SHALL leave iq_cnt unchanged; dispatch into empty queue SHALL not be selectable in its dispatch cycle.
REQ-019 flush SHALL clear all valid bits, iq_cnt to 0 and ALU0_vld to 0 at the next edge, overriding dispatch, select and wakeup; ALU0_wake_vld SHALL be 0 while flush=1.
REQ-020 Physical register 0 SHALL be treated as always ready (tags matching 6'd0 set ready at dispatch).

Reset
REQ-021 rst=1 SHALL asynchronously clear all entry valid bits, iq_cnt=0, iq_full=0, ALU0_vld=0; payload registers need no reset.
REQ-022 Reset asserted mid-operation SHALL discard all entries; first dispatch after deassertion SHALL land in entry 0.

Structure
REQ-023 Shared package SHALL hold IQ_DEPTH, OP_W=5, PR_W=6, ROB_W=6 and the ALU0 op encodings 0..23.
REQ-024 One sub-module SHALL be natural: iq_select_alu0, an 8-bit lowest-index-first priority encoder returning one-hot grant and index.

Verification
REQ-025 Dispatch op=7 dest=10 both ready at cycle 0 -> ALU0_wake_vld at cycle 1, ALU0_vld=1 dest=10 at cycle 2, iq_cnt back to 0.
REQ-026 Dispatch A (dest=10, ready) then B (src1=10, not ready) -> B selected exactly one cycle after A, back-to-back issue.
REQ-027 Fill 8 non-ready entries -> iq_full=1; extra dispatch dropped; BRU_wake_PR matching entry 3 -> entry 3 issues, cnt=7, iq_full=0.
REQ-028 Entries 0 and 2 ready simultaneously -> entry 0 issues first, entry 2 (now index 1) next cycle; order of ROB_IDs preserved.
REQ-029 5 entries queued, flush=1 for one cycle -> iq_cnt=0, ALU0_vld=0 next cycle, no later issue of flushed ROB_IDs.
REQ-030 rst pulse mid-stream with 4 entries -> all outputs reset immediately; post-reset dispatch issues normally with cnt=1.
